// File: rtl/alu_serial_pkg.sv
// Shared types and helpers for the nibble-serial ALU sequencer.
// Used by alu_nibble_serial (optional zero flag: ALU_SERIAL_ZERO_FLAG_EN).
package alu_serial_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int nibble_count(input int width);
        return width / NIBBLE;
    endfunction

endpackage

// File: rtl/alu_nibble_serial_alu4.sv
// ALU_4bit: combinational 4-bit ALU, active-high data with
// active-low carry in/out (S/M function set of the classic 181 part).
module ALU_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] S,
    input  logic       M,
    input  logic       Cin,
    output logic [3:0] F,
    output logic       Cout
);

    logic [3:0] w_x;
    logic [3:0] w_y;
    logic [4:0] w_sum;

    // Arithmetic is X plus Y plus carry; logic is the carry-free XNOR.
    assign w_x   = A | (B & {4{S[0]}}) | (~B & {4{S[1]}});
    assign w_y   = (A & ~B & {4{S[2]}}) | (A & B & {4{S[3]}});
    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {4'b0000, ~Cin};
    assign F     = M ? ~(w_x ^ w_y) : w_sum[3:0];
    assign Cout  = ~w_sum[4];

endmodule

// File: rtl/alu_nibble_serial.sv
// Nibble-serial WIDTH-bit ALU around one ALU_4bit, valid/ready on both sides.
// Define ALU_SERIAL_ZERO_FLAG_EN to add the registered zero output.
module alu_nibble_serial
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    output logic             cout,
    output logic             zero
`else
    output logic             cout
`endif
);

    localparam int N  = nibble_count(WIDTH);
    localparam int CW = $clog2(N);

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_f;
    logic [3:0]        r_s;
    logic              r_m;
    logic              r_carry;
    logic [NIBBLE-1:0] w_a;
    logic [NIBBLE-1:0] w_b;
    logic [NIBBLE-1:0] w_f;
    logic              w_cout;
    logic              w_last;
    logic              w_accept;
    logic              w_run;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_run    = (r_state == RUN);
    assign w_last   = (r_cnt == CW'(N - 1));
    assign w_a      = r_a[int'(r_cnt)*NIBBLE +: NIBBLE];
    assign w_b      = r_b[int'(r_cnt)*NIBBLE +: NIBBLE];

    ALU_4bit u_alu (
        .A    (w_a),
        .B    (w_b),
        .S    (r_s),
        .M    (r_m),
        .Cin  (r_carry),
        .F    (w_f),
        .Cout (w_cout)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_m     <= 1'b0;
            r_carry <= 1'b0;
            r_f     <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_a     <= a;
            r_b     <= b;
            r_s     <= s;
            r_m     <= m;
            r_carry <= cin;
        end else if (w_run) begin
            r_f[int'(r_cnt)*NIBBLE +: NIBBLE] <= w_f;
            r_carry <= w_cout;
            if (!w_last) r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef ALU_SERIAL_ZERO_FLAG_EN
    logic r_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_zero <= 1'b1;
        else if (w_accept) r_zero <= 1'b1;
        else if (w_run)    r_zero <= r_zero & (w_f == '0);
    end

    assign zero = r_zero;
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign f         = r_f;
    assign cout      = r_carry;

endmodule

// File: tb/tb_alu_nibble_serial.sv
// Self-checking bench for alu_nibble_serial against a table-driven
// behavioural model of ALU_4bit chained nibble by nibble on raw Cout.
module tb_alu_nibble_serial;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [3:0]    s;
    logic          m;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  f;
    logic          cout;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    logic          zero;
`endif

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] nxt_a;
    logic [W-1:0] nxt_b;
    logic [3:0]   nxt_s;
    logic         nxt_m;
    logic         nxt_c;

    always #5 clk = ~clk;

    alu_nibble_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .s         (s),
        .m         (m),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        .cout      (cout),
        .zero      (zero)
`else
        .cout      (cout)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {cout_n, f}; carry in/out are active-low.
    function automatic logic [4:0] alu4(input logic [3:0] ta, tb,
                                        input logic [3:0] ts,
                                        input logic tm, tc);
        logic [3:0] nb, aob, aonb, aanb, aab, lf;
        int ia, ib, iaob, iaonb, iaanb, iaab, val, c;
        nb = ~tb;
        aob = ta | tb;
        aonb = ta | nb;
        aanb = ta & nb;
        aab = ta & tb;
        ia = int'(ta);
        ib = int'(tb);
        iaob = int'(aob);
        iaonb = int'(aonb);
        iaanb = int'(aanb);
        iaab = int'(aab);
        c = tc ? 0 : 1;
        case (ts)
            4'd0:  val = ia;
            4'd1:  val = iaob;
            4'd2:  val = iaonb;
            4'd3:  val = 15;
            4'd4:  val = ia + iaanb;
            4'd5:  val = iaob + iaanb;
            4'd6:  val = ia - ib - 1 + 16;
            4'd7:  val = iaanb - 1 + 16;
            4'd8:  val = ia + iaab;
            4'd9:  val = ia + ib;
            4'd10: val = iaonb + iaab;
            4'd11: val = iaab - 1 + 16;
            4'd12: val = ia + ia;
            4'd13: val = iaob + ia;
            4'd14: val = iaonb + ia;
            default: val = ia - 1 + 16;
        endcase
        val = val + c;
        case (ts)
            4'd0:  lf = ~ta;
            4'd1:  lf = ~aob;
            4'd2:  lf = ~ta & tb;
            4'd3:  lf = 4'h0;
            4'd4:  lf = ~aab;
            4'd5:  lf = nb;
            4'd6:  lf = ta ^ tb;
            4'd7:  lf = aanb;
            4'd8:  lf = ~ta | tb;
            4'd9:  lf = ~(ta ^ tb);
            4'd10: lf = tb;
            4'd11: lf = aab;
            4'd12: lf = 4'hF;
            4'd13: lf = aonb;
            4'd14: lf = aob;
            default: lf = ta;
        endcase
        if (!tm) lf = 4'(val % 16);
        return {(val < 16), lf};
    endfunction

    function automatic logic [W:0] serial_model(input logic [W-1:0] ta, tb,
                                                input logic [3:0] ts,
                                                input logic tm, tc);
        logic [W-1:0] rf;
        logic [4:0]   r;
        logic         c;
        c = tc;
        rf = '0;
        for (int i = 0; i < NIB; i++) begin
            r = alu4(ta[4*i +: 4], tb[4*i +: 4], ts, tm, c);
            rf[4*i +: 4] = r[3:0];
            c = r[4];
        end
        return {c, rf};
    endfunction

    task automatic do_op(input logic [W-1:0] ta, tb, input logic [3:0] ts,
                         input logic tm, tc, input int stall,
                         input bit drive_next, input bit use_k,
                         input logic [W-1:0] kf);
        logic [W:0] exp;
        exp = serial_model(ta, tb, ts, tm, tc);
        @(negedge clk);
        a = ta; b = tb; s = ts; m = tm; cin = tc;
        in_valid = 1'b1;
        chk("accept_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom);
        s = 4'($urandom); m = 1'($urandom); cin = 1'($urandom);
        chk("run_in_ready", 32'(in_ready), 32'd0);
        for (int i = 1; i <= NIB; i++) begin
            @(posedge clk); #1;
            chk("latency_out_valid", 32'(out_valid), 32'(i == NIB));
        end
        chk("f", 32'(f), 32'(exp[W-1:0]));
        chk("cout", 32'(cout), 32'(exp[W]));
        if (use_k) chk("f_const", 32'(f), 32'(kf));
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        chk("zero", 32'(zero), 32'(exp[W-1:0] == '0));
`endif
        for (int j = 0; j < stall; j++) begin
            if (drive_next) begin
                in_valid = 1'b1;
                a = nxt_a; b = nxt_b; s = nxt_s; m = nxt_m; cin = nxt_c;
            end
            @(posedge clk); #1;
            chk("stall_f", 32'(f), 32'(exp[W-1:0]));
            chk("stall_cout", 32'(cout), 32'(exp[W]));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hs_out_valid", 32'(out_valid), 32'd0);
        chk("hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; s = '0; m = 1'b0; cin = 1'b1;
        nxt_a = '0; nxt_b = '0; nxt_s = '0; nxt_m = 1'b0; nxt_c = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_f", 32'(f), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        chk("rst_zero", 32'(zero), 32'd1);
`endif

        do_op(16'hA5F0, 16'h0FF0, 4'b0110, 1'b1, 1'b1, 0, 0, 1, 16'hAA00);
        do_op(16'h1234, 16'h0000, 4'b1011, 1'b1, 1'b1, 0, 0, 1, 16'h0000);
        do_op(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0, 0, 0, 1, 16'h0101);
        do_op(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1, 0, 0, 1, 16'h0100);

        nxt_a = 16'h7F3C; nxt_b = 16'h1111; nxt_s = 4'b1001;
        nxt_m = 1'b0; nxt_c = 1'b1;
        do_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 5, 1, 1, 16'h0000);
        do_op(nxt_a, nxt_b, nxt_s, nxt_m, nxt_c, 0, 0, 1, 16'h904D);

        @(negedge clk);
        a = 16'h4321; b = 16'h1111; s = 4'b1001; m = 1'b0; cin = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_f", 32'(f), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NIB + 4; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_result", 32'(out_valid), 32'd0);
        end
        do_op(16'hFFFF, 16'h0000, 4'b0000, 1'b1, 1'b1, 0, 0, 1, 16'h0000);

        for (int k = 0; k < 24; k++) begin
            do_op(W'($urandom), W'($urandom), 4'($urandom), 1'($urandom),
                  1'($urandom), int'($urandom_range(0, 2)), 0, 0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_nibble_serial.md
# alu_nibble_serial

Nibble-serial multi-word ALU sequencer. Accepts a WIDTH-bit operation request over a valid/ready handshake and evaluates it on a single instance of the existing combinational `ALU_4bit`, one nibble per clock, least-significant nibble first. It ripples `Cout` into the next nibble's `Cin` and returns the assembled result over a second valid/ready handshake. It sits between the operand/opcode source and result consumers, and is the only clocked wrapper around `ALU_4bit`.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- s  input  4  ALU function select, passed unchanged to `ALU_4bit` S.
- m  input  1  mode (0 = arithmetic, 1 = logic), passed to `ALU_4bit` M.
- cin  input  1  carry into nibble 0, at `ALU_4bit` Cin polarity.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- f  output  WIDTH  result.
- cout  output  1  `Cout` of the most-significant nibble.
- zero  output  1  f == 0. Present only with the macro; see Configuration.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, capture a, b, s, m and cin into internal registers.
  - Clear the nibble counter to 0 and go to RUN.
- RUN:
  - in_ready = 0. `ALU_4bit` sees A = a_reg[4i+3:4i], B = b_reg[4i+3:4i], S = s_reg, M = m_reg, Cin = carry_reg, where i is the counter value.
  - Each edge writes F into f_reg[4i+3:4i], writes Cout into carry_reg, and increments i.
  - After writing nibble N-1 (N = WIDTH/4), go to DONE.
- carry_reg loads cin at accept. Carry is rippled raw, with no inversion between nibbles.
- In logic mode, the rippled carry is whatever `ALU_4bit` produces. It has no effect on F.
- DONE:
  - out_valid = 1; f = f_reg; cout = carry_reg.
  - On out_ready, go to IDLE.
  - f and cout hold stable while out_valid && !out_ready.
- Requests do not overlap. in_ready is deasserted in RUN and DONE. Inputs that change after the accept edge are ignored.
- Counter width is clog2(N). The counter never wraps within an operation.

## Timing
- Reset (async assert, sync to clk on release):
  - State goes to IDLE.
  - in_ready = 1, out_valid = 0, f = 0, cout = 0, zero = 1.
  - Counter and carry_reg = 0.
- Latency: request accepted at edge k; nibble i is written at edge k+1+i; out_valid rises after edge k+N (N = 4 for WIDTH=16).
- out_valid && out_ready at edge j: out_valid falls and in_ready rises after edge j. The next accept is possible at edge j+1.
- Best-case throughput: one operation per N+2 cycles.
- Reset asserted mid-RUN or in DONE: the operation is discarded immediately and no result is presented. After release, the block behaves as if freshly reset.
- in_valid held high across DONE: the request is not accepted until the cycle after the result handshake.
- f is registered. No combinational path exists from a, b, s, m or cin to any output.

## Configuration
- ALU_SERIAL_ZERO_FLAG_EN:
  - Defined: the zero output port exists.
  - zero is registered and valid with out_valid. It is computed as the AND of "nibble F == 0" over all nibbles, accumulated during RUN.
  - It is set to 1 at accept and is 1 after reset.
- Undefined: no zero port and no accumulation logic.

## Structure
- Package `alu_serial_pkg`:
  - NIBBLE = 4 constant.
  - State enum {IDLE, RUN, DONE}.
  - Function nibble_count(width) = width/4.
- Sub-module: one instance of the existing `ALU_4bit`, unmodified.
- Everything else stays in this module: handshake FSM, counter, operand registers, result register and carry register.

## Test plan
- Reset then idle: hold rst_n low 3 cycles, then release -> in_ready=1, out_valid=0, f=0, cout=0, zero=1 (macro defined).
- Logic XOR: a=16'hA5F0, b=16'h0FF0, s=4'b0110, m=1 -> f=16'hAA00 exactly 4 cycles after accept; zero=0.
- Logic AND, zero flag: a=16'h1234, b=16'h0000, s=4'b1011, m=1 -> f=16'h0000, zero=1.
- Carry ripple across nibbles: m=0, s=4'b1001 (A plus B), a=16'h00FF, b=16'h0001, cin at `ALU_4bit` carry-in-active level -> f=16'h0101. With carry-inactive cin -> f=16'h0100. The bench checks nibble-wise against a behavioural model of `ALU_4bit` chained on raw Cout.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> f and cout are stable and in_ready=0 throughout. Drive in_valid=1 with new operands during the stall -> they are not accepted until the cycle after out_ready=1.
- Reset mid-operation: assert rst_n low at the second RUN cycle -> out_valid never rises for that request. After release, a new request (a=16'hFFFF, b=16'h0000, s=4'b0000, m=1, i.e. NOT A) -> f=16'h0000.
